vip_dehaze_recover: RTL
=======================

VIP_DEHAZE_RECOVER -- requirements
Module: vip_dehaze_recover

Interface
REQ-001 SHALL have parameter DW, default 8: pixel and channel width.
REQ-002 SHALL have parameter CH, default 3: colour channel count; channel k is per_img_data[k*DW +: DW].
REQ-003 SHALL have parameter FRAC, default 8: fractional bits of the reciprocal.
REQ-004 SHALL have parameter T0, default 26: transmission floor; range 1..2^DW-1.
REQ-005 SHALL have parameter A_FLOOR, default 64: minimum estimated atmospheric light.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port reset_p, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have ports per_frame_vsync, per_frame_href and per_frame_clken, input, 1 bit each: input sync; vsync is high for the whole frame, and clken qualifies each pixel.
REQ-009 SHALL have port per_img_data, input, CH*DW bits: hazy pixel, aligned with per_transmission.
REQ-010 SHALL have port per_img_dark, input, DW bits: filtered dark channel, same alignment.
REQ-011 SHALL have port per_transmission, input, DW bits: t, where 2^DW-1 means 1.0.
REQ-012 SHALL have port cfg_mode, input, 2 bits: 0 dehaze, 1 bypass, 2 transmission view, 3 A view.
REQ-013 SHALL have ports cfg_a_manual (input, 1 bit) and cfg_a_value (input, DW bits): manual atmospheric-light override.
REQ-014 SHALL have ports post_frame_vsync, post_frame_href and post_frame_clken, output, 1 bit each: delayed sync.
REQ-015 SHALL have port post_img_data, output, CH*DW bits: result pixel.
REQ-016 SHALL have port atm_light, output, DW bits: the A value currently applied.

Function
REQ-017 SHALL define frame start as a rising edge of per_frame_vsync (registered previous value is 0, current value is 1).
REQ-018 Estimator: SHALL hold frame_max, updated to max(frame_max, per_img_dark) on every cycle where per_frame_clken is 1.
REQ-019 At each frame start, frame_max SHALL clear to 0, and the same cycle's clken pixel, if any, SHALL seed it.
REQ-020 At frame start with frame_seen=1, a_est SHALL load max(frame_max, A_FLOOR).
REQ-021 The first frame start after reset SHALL leave a_est unchanged and set frame_seen to 1.
REQ-022 Frame-boundary latching: cfg_mode, cfg_a_manual and cfg_a_value SHALL be sampled only at frame start, and mid-frame changes SHALL have no effect until the next frame.
REQ-023 A_use SHALL equal the latched cfg_a_value when the latched manual bit is 1, otherwise a_est; atm_light SHALL show A_use.
REQ-024 Pipeline latency SHALL be exactly 3 clk cycles; all three sync outputs SHALL be the inputs delayed by 3 cycles, and the pipeline SHALL never stall.
REQ-025 Stage 1 SHALL compute tc = max(per_transmission, T0) and the signed d_k = I_k - A_use, width DW+1 bits.
REQ-026 Stage 1 SHALL register R = floor((2^DW-1)*2^FRAC / tc) from a ROM built at elaboration, width DW+FRAC bits.
REQ-027 Stage 2 SHALL register the signed product p_k = d_k*R, width 2*DW+FRAC+1 bits.
REQ-028 Stage 3 SHALL compute J_k = A_use + (p_k >>> FRAC), using an arithmetic (floor) shift, and saturate to 0..2^DW-1.
REQ-029 Mode 1 SHALL output I unchanged; mode 2 SHALL place tc on every channel; mode 3 SHALL place A_use on every channel, all with the same 3-cycle latency.
REQ-030 post_img_data SHALL update only on pipeline cycles whose delayed clken is 1, and SHALL hold otherwise.
REQ-031 Simultaneous frame start and clken SHALL both take effect in that cycle: the new A_use and mode apply to that pixel.

Reset
REQ-032 In any reset cycle, all sync outputs and post_img_data SHALL be 0 on the next edge; frame_max and frame_seen SHALL be 0; a_est SHALL be 2^DW-1; latched mode SHALL be 0 and latched manual bit 0; atm_light SHALL be 2^DW-1.
REQ-033 Reset mid-frame SHALL discard pipeline contents and the partial frame_max; the next frame start SHALL be treated as the first frame start after reset.

Structure
REQ-034 The mode encodings and the reciprocal-ROM generator function SHALL live in shared package vip_dehaze_pkg.
REQ-035 The estimator and frame-boundary latch SHALL be sub-module vip_atm_light_est; the datapath SHALL stay in vip_dehaze_recover.

Verification
REQ-036 Use DW=8 and defaults. Identity: A=200 (manual), t=255, I=150 on all channels -> J=150, exactly 3 cycles after clken.
REQ-037 Darken: A=200, t=128, I=180 -> R=510, J=160.
REQ-038 Floor and saturation: A=200, t=10, I=210 -> tc=26, R=2510, J=255.
REQ-039 Underflow: A=200, t=128, I=100 -> J=0.
REQ-040 Estimator: after reset, frame 1 dark max 180 -> atm_light=255 throughout frame 2's start cycle, then 180; a frame with max 30 -> next A=64; a reset mid-frame -> A stays 255 over the next two frame starts' first edge.
REQ-041 Mode latch: cfg_mode changed 0->2 mid-frame -> output is the dehazed result until the next frame start, then tc on all channels; sync outputs match the inputs delayed by 3 cycles throughout.

Source files
------------

// File: rtl/vip_dehaze_pkg.sv
// rtl/vip_dehaze_pkg.sv - shared mode encodings and reciprocal-ROM generator for the dehaze recovery path
package vip_dehaze_pkg;

  typedef enum logic [1:0] {
    MODE_DEHAZE = 2'd0,
    MODE_BYPASS = 2'd1,
    MODE_TVIEW  = 2'd2,
    MODE_AVIEW  = 2'd3
  } mode_e;

  // floor(full_scale * 2^frac / tc); index 0 is unreachable behind the T0 floor
  function automatic longint recip_calc(input int dw, input int frac, input int tc);
    longint num;
    num = ((longint'(1) << dw) - 1) << frac;
    if (tc == 0) return num;
    return num / tc;
  endfunction

endpackage

// File: rtl/vip_atm_light_est.sv
// rtl/vip_atm_light_est.sv - per-frame atmospheric-light estimator and frame-boundary config latch
module vip_atm_light_est
  import vip_dehaze_pkg::*;
#(
  parameter int DW      = 8,
  parameter int A_FLOOR = 64
) (
  input  logic          clk,
  input  logic          reset_p,
  input  logic          vsync,
  input  logic          clken,
  input  logic [DW-1:0] dark,
  input  logic [1:0]    cfg_mode,
  input  logic          cfg_a_manual,
  input  logic [DW-1:0] cfg_a_value,
  output logic [DW-1:0] a_use,
  output logic [1:0]    mode_use,
  output logic [DW-1:0] atm_light
);
  localparam logic [DW-1:0] A_FLOOR_V = DW'(A_FLOOR);

  logic          vsync_prev_q, vsync_prev_d;
  logic [DW-1:0] frame_max_q, frame_max_d;
  logic          frame_seen_q, frame_seen_d;
  logic [DW-1:0] a_est_q, a_est_d;
  logic [1:0]    mode_q, mode_d;
  logic          manual_q, manual_d;
  logic [DW-1:0] a_value_q, a_value_d;
  logic          frame_start;

  always_comb begin
    frame_start  = vsync & ~vsync_prev_q;
    vsync_prev_d = vsync;
    frame_max_d  = frame_max_q;
    frame_seen_d = frame_seen_q;
    a_est_d      = a_est_q;
    mode_d       = mode_q;
    manual_d     = manual_q;
    a_value_d    = a_value_q;
    if (frame_start) begin
      frame_max_d  = clken ? dark : '0;
      frame_seen_d = 1'b1;
      if (frame_seen_q) a_est_d = (frame_max_q > A_FLOOR_V) ? frame_max_q : A_FLOOR_V;
      mode_d    = cfg_mode;
      manual_d  = cfg_a_manual;
      a_value_d = cfg_a_value;
    end else if (clken && (dark > frame_max_q)) begin
      frame_max_d = dark;
    end
    // Next-state view lets a pixel arriving on the frame-start cycle use the new frame's settings
    a_use     = manual_d ? a_value_d : a_est_d;
    mode_use  = mode_d;
    atm_light = manual_q ? a_value_q : a_est_q;
  end

  always_ff @(posedge clk) begin
    // vsync_prev follows the input even in reset so a frame already in progress is not seen as a new start
    vsync_prev_q <= vsync_prev_d;
    if (reset_p) begin
      frame_max_q  <= '0;
      frame_seen_q <= 1'b0;
      a_est_q      <= '1;
      mode_q       <= MODE_DEHAZE;
      manual_q     <= 1'b0;
      a_value_q    <= '0;
    end else begin
      frame_max_q  <= frame_max_d;
      frame_seen_q <= frame_seen_d;
      a_est_q      <= a_est_d;
      mode_q       <= mode_d;
      manual_q     <= manual_d;
      a_value_q    <= a_value_d;
    end
  end

endmodule

// File: rtl/vip_dehaze_recover.sv
// rtl/vip_dehaze_recover.sv - 3-stage scene recovery J = A + (I - A) / max(t, T0)
module vip_dehaze_recover
  import vip_dehaze_pkg::*;
#(
  parameter int DW      = 8,
  parameter int CH      = 3,
  parameter int FRAC    = 8,
  parameter int T0      = 26,
  parameter int A_FLOOR = 64
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             per_frame_vsync,
  input  logic             per_frame_href,
  input  logic             per_frame_clken,
  input  logic [CH*DW-1:0] per_img_data,
  input  logic [DW-1:0]    per_img_dark,
  input  logic [DW-1:0]    per_transmission,
  input  logic [1:0]       cfg_mode,
  input  logic             cfg_a_manual,
  input  logic [DW-1:0]    cfg_a_value,
  output logic             post_frame_vsync,
  output logic             post_frame_href,
  output logic             post_frame_clken,
  output logic [CH*DW-1:0] post_img_data,
  output logic [DW-1:0]    atm_light
);
  localparam int RW = DW + FRAC;
  localparam int PW = 2 * DW + FRAC + 1;
  localparam logic [DW-1:0] T0_V = DW'(T0);
  localparam logic signed [PW-1:0] MAX_V = $signed({{(PW-DW){1'b0}}, {DW{1'b1}}});

  logic [DW-1:0] a_use;
  logic [1:0]    mode_use;

  vip_atm_light_est #(.DW(DW), .A_FLOOR(A_FLOOR)) u_est (
    .clk          (clk),
    .reset_p      (reset_p),
    .vsync        (per_frame_vsync),
    .clken        (per_frame_clken),
    .dark         (per_img_dark),
    .cfg_mode     (cfg_mode),
    .cfg_a_manual (cfg_a_manual),
    .cfg_a_value  (cfg_a_value),
    .a_use        (a_use),
    .mode_use     (mode_use),
    .atm_light    (atm_light)
  );

  logic [RW-1:0] recip_rom [2**DW];
  for (genvar g = 0; g < 2**DW; g++) begin : g_rom
    localparam longint RV = recip_calc(DW, FRAC, g);
    assign recip_rom[g] = RV[RW-1:0];
  end

  logic [2:0]             sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic signed [DW:0]     d1_q [CH];
  logic [DW:0]            d1_d [CH];
  logic [RW-1:0]          r1_q, r1_d;
  logic [DW-1:0]          tc1_q, tc1_d, tc2_q, tc2_d, a1_q, a1_d, a2_q, a2_d;
  logic [1:0]             mode1_q, mode1_d, mode2_q, mode2_d;
  logic [CH*DW-1:0]       img1_q, img1_d, img2_q, img2_d, pix_q, pix_d;
  logic signed [PW-1:0]   p2_q [CH];
  logic signed [PW-1:0]   p2_d [CH];
  logic signed [PW-1:0]   acc [CH];

  always_comb begin
    sync1_d = {per_frame_vsync, per_frame_href, per_frame_clken};
    tc1_d   = (per_transmission < T0_V) ? T0_V : per_transmission;
    r1_d    = recip_rom[tc1_d];
    a1_d    = a_use;
    mode1_d = mode_use;
    img1_d  = per_img_data;
    for (int k = 0; k < CH; k++) d1_d[k] = {1'b0, per_img_data[k*DW +: DW]} - {1'b0, a_use};

    sync2_d = sync1_q;
    tc2_d   = tc1_q;
    a2_d    = a1_q;
    mode2_d = mode1_q;
    img2_d  = img1_q;
    for (int k = 0; k < CH; k++)
      p2_d[k] = $signed({{(PW-DW-1){d1_q[k][DW]}}, d1_q[k]}) * $signed({{(PW-RW){1'b0}}, r1_q});

    sync3_d = sync2_q;
    pix_d   = pix_q;
    for (int k = 0; k < CH; k++) begin
      acc[k] = $signed({{(PW-DW){1'b0}}, a2_q}) + (p2_q[k] >>> FRAC);
      if (sync2_q[0]) begin
        case (mode2_q)
          MODE_BYPASS: pix_d[k*DW +: DW] = img2_q[k*DW +: DW];
          MODE_TVIEW:  pix_d[k*DW +: DW] = tc2_q;
          MODE_AVIEW:  pix_d[k*DW +: DW] = a2_q;
          default: begin
            if (acc[k] < 0)          pix_d[k*DW +: DW] = '0;
            else if (acc[k] > MAX_V) pix_d[k*DW +: DW] = '1;
            else                     pix_d[k*DW +: DW] = acc[k][DW-1:0];
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      sync1_q <= '0; sync2_q <= '0; sync3_q <= '0;
      r1_q    <= '0; tc1_q <= '0; tc2_q <= '0; a1_q <= '0; a2_q <= '0;
      mode1_q <= '0; mode2_q <= '0; img1_q <= '0; img2_q <= '0; pix_q <= '0;
      for (int k = 0; k < CH; k++) begin
        d1_q[k] <= '0;
        p2_q[k] <= '0;
      end
    end else begin
      sync1_q <= sync1_d; sync2_q <= sync2_d; sync3_q <= sync3_d;
      r1_q    <= r1_d; tc1_q <= tc1_d; tc2_q <= tc2_d; a1_q <= a1_d; a2_q <= a2_d;
      mode1_q <= mode1_d; mode2_q <= mode2_d; img1_q <= img1_d; img2_q <= img2_d; pix_q <= pix_d;
      for (int k = 0; k < CH; k++) begin
        d1_q[k] <= $signed(d1_d[k]);
        p2_q[k] <= p2_d[k];
      end
    end
  end

  assign {post_frame_vsync, post_frame_href, post_frame_clken} = sync3_q;
  assign post_img_data = pix_q;

endmodule
